// File: rtl/mxu_ctrl_pkg.sv
// mxu_ctrl_pkg: shared types and precision codes for MXU sequencers.
// Codes mirror the INT8/16/32/64 values of the precision header.
package mxu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } smul_ctrl_state_t;

  localparam logic [3:0] PREC_INT8  = 4'h0;
  localparam logic [3:0] PREC_INT16 = 4'h1;
  localparam logic [3:0] PREC_INT32 = 4'h2;
  localparam logic [3:0] PREC_INT64 = 4'h3;

  function automatic logic prec_valid(
    input logic [3:0] p
  );
    return (p == PREC_INT8)  ||
           (p == PREC_INT16) ||
           (p == PREC_INT32) ||
           (p == PREC_INT64);
  endfunction

endpackage

// File: rtl/smul_vld_pipe.sv
// smul_vld_pipe: valid shadow of the smul datapath.
// Advances only when the multiplier clock enable is high.
module smul_vld_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic sresetn,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;

  always_comb begin
    vld_nxt    = vld << 1;
    vld_nxt[0] = din;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      vld <= '0;
    end else if (en) begin
      vld <= vld_nxt;
    end
  end

  assign dout = vld[DEPTH-1];

endmodule

// File: rtl/smul_ctrl.sv
// smul_ctrl: job sequencer for one smul systolic multiplier.
// Clears the unit, streams operand pairs, returns ordered results.
module smul_ctrl
  import mxu_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int LEN_W    = 8,
  parameter int CLR_CYC  = 1
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_precision,
  input  logic [1:0]       cfg_fp,
  input  logic             cfg_chain,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [63:0]      in_weight,
  output logic             mul_ce,
  output logic             mul_sclr,
  output logic [63:0]      mul_input_data,
  output logic [63:0]      mul_weight,
  output logic [3:0]       mul_select_precision,
  output logic [1:0]       mul_enable_fp_unit,
  output logic             mul_active_chain,
  input  logic [63:0]      mul_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int CLR_W =
    (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  smul_ctrl_state_t state;
  smul_ctrl_state_t state_nxt;

  logic [CLR_W-1:0] clr_cnt;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] retired;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       prec_q;
  logic [1:0]       fp_q;
  logic             chain_q;
  logic             rst_q;
  logic             err_q;

  logic cfg_ok;
  logic cfg_take;
  logic st_run;
  logic st_drain;
  logic stall;
  logic in_fire;
  logic out_fire;
  logic clr_end;
  logic issue_end;

  assign cfg_ok   = prec_valid(cfg_precision);
  assign cfg_take = (state == S_IDLE)
                  && cfg_valid && cfg_ok;
  assign st_run   = (state == S_RUN);
  assign st_drain = (state == S_DRAIN);

  assign stall    = out_valid && !out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign clr_end  = clr_cnt == CLR_W'(CLR_CYC - 1);

  // counts the beat transferring this cycle
  assign issue_end =
    (issued + LEN_W'(in_fire)) == len_q;

  assign in_ready = st_run && !stall
                  && (issued < len_q);

  assign mul_ce = (state == S_CLEAR)
                || ((st_run || st_drain) && !stall);

  // held high through reset and its first cycle
  assign mul_sclr = rst_q || (state == S_CLEAR);

  assign mul_input_data = in_fire ? in_data   : '0;
  assign mul_weight     = in_fire ? in_weight : '0;

  assign mul_select_precision = prec_q;
  assign mul_enable_fp_unit   = fp_q;
  assign mul_active_chain     = chain_q;

  assign out_data = mul_res;
  assign out_last = out_valid
    && (retired == (len_q - LEN_W'(1)));

  assign cfg_ready = (state == S_IDLE);
  assign cfg_err   = err_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  smul_vld_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_vld_pipe (
    .clk     (clk),
    .sresetn (sresetn),
    .en      (mul_ce),
    .din     (in_fire),
    .dout    (out_valid)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cfg_take) begin
          state_nxt = (cfg_len == '0)
                    ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_end) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (issue_end) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_fire && out_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      issued  <= '0;
      retired <= '0;
      len_q   <= '0;
      prec_q  <= '0;
      fp_q    <= '0;
      chain_q <= 1'b0;
      rst_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      rst_q <= 1'b0;
      err_q <= (state == S_IDLE)
             && cfg_valid && !cfg_ok;
      if (cfg_take) begin
        len_q   <= cfg_len;
        prec_q  <= cfg_precision;
        fp_q    <= cfg_fp;
        chain_q <= cfg_chain;
      end
      if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + CLR_W'(1);
        issued  <= '0;
        retired <= '0;
      end else begin
        clr_cnt <= '0;
        if (in_fire) begin
          issued <= issued + LEN_W'(1);
        end
        if (out_fire) begin
          retired <= retired + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_smul_ctrl.sv
// tb_smul_ctrl: randomized jobs against a queue-based reference.
// A behavioural smul stub stands in for the multiplier.
module tb_smul_ctrl;
  import mxu_ctrl_pkg::*;

  localparam int PIPE_LAT = 2;
  localparam int LEN_W    = 8;
  localparam int CLR_CYC  = 1;

  logic             clk = 1'b0;
  logic             sresetn;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_precision;
  logic [1:0]       cfg_fp;
  logic             cfg_chain;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic [63:0]      in_weight;
  logic             mul_ce;
  logic             mul_sclr;
  logic [63:0]      mul_input_data;
  logic [63:0]      mul_weight;
  logic [3:0]       mul_select_precision;
  logic [1:0]       mul_enable_fp_unit;
  logic             mul_active_chain;
  logic [63:0]      mul_res;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0]  last_prec = '0;
  logic [63:0] sp [PIPE_LAT];

  smul_ctrl #(
    .PIPE_LAT (PIPE_LAT),
    .LEN_W    (LEN_W),
    .CLR_CYC  (CLR_CYC)
  ) dut (
    .clk                  (clk),
    .sresetn              (sresetn),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_precision        (cfg_precision),
    .cfg_fp               (cfg_fp),
    .cfg_chain            (cfg_chain),
    .cfg_len              (cfg_len),
    .cfg_err              (cfg_err),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .in_weight            (in_weight),
    .mul_ce               (mul_ce),
    .mul_sclr             (mul_sclr),
    .mul_input_data       (mul_input_data),
    .mul_weight           (mul_weight),
    .mul_select_precision (mul_select_precision),
    .mul_enable_fp_unit   (mul_enable_fp_unit),
    .mul_active_chain     (mul_active_chain),
    .mul_res              (mul_res),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_last             (out_last),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mulf(
    input logic [63:0] d,
    input logic [63:0] w,
    input logic [3:0]  p,
    input logic [1:0]  f,
    input logic        c
  );
    return (d * w) ^ {57'b0, c, f, p};
  endfunction

  // smul stand-in: PIPE_LAT stages, frozen when ce is low
  always @(posedge clk) begin
    if (mul_sclr) begin
      for (int i = 0; i < PIPE_LAT; i++) sp[i] <= '0;
    end else if (mul_ce) begin
      sp[0] <= mulf(mul_input_data, mul_weight,
                    mul_select_precision,
                    mul_enable_fp_unit,
                    mul_active_chain);
      for (int i = 1; i < PIPE_LAT; i++) sp[i] <= sp[i-1];
    end
  end
  assign mul_res = sp[PIPE_LAT-1];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(
    input logic [3:0] p,
    input logic [1:0] fp,
    input logic       ch,
    input int         len,
    input int         imode,
    input int         omode,
    input bit         lat,
    input bit         fixed
  );
    logic [63:0] expq[$];
    int icyc[$];
    int issued, retired, t_acc, t_last, n, k;
    bit fin, fire;
    cfg_valid     = 1'b1;
    cfg_precision = p;
    cfg_fp        = fp;
    cfg_chain     = ch;
    cfg_len       = LEN_W'(len);
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    @(negedge clk);
    chk("cfg_ready", 64'(cfg_ready), 64'd1);
    t_acc = cyc;
    tick();
    cfg_valid = 1'b0;
    last_prec = p;
    issued = 0; retired = 0; t_last = 0;
    fin = 1'b0; n = 0;
    while (!fin && n < 40 * len + 50) begin
      case (imode)
        0:       in_valid = 1'b1;
        1:       in_valid = (n % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (fixed) begin
        in_data   = 64'hcafecafecafecafe;
        in_weight = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        in_data   = {$urandom, $urandom};
        in_weight = {$urandom, $urandom};
      end
      case (omode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      k = cyc - t_acc;
      chk("busy", 64'(busy), 64'd1);
      if (len != 0 && k <= CLR_CYC) begin
        chk("sclr_on", 64'(mul_sclr), 64'd1);
        chk("ce_clear", 64'(mul_ce), 64'd1);
      end else begin
        chk("sclr_off", 64'(mul_sclr), 64'd0);
      end
      fire = in_valid && in_ready;
      if (issued == len) begin
        chk("in_ready_end", 64'(in_ready), 64'd0);
      end
      if (fire) begin
        expq.push_back(mulf(in_data, in_weight,
                            p, fp, ch));
        icyc.push_back(cyc);
        issued++;
        chk("mul_data", mul_input_data, in_data);
      end else begin
        chk("mul_op_zero",
            mul_input_data | mul_weight, 64'd0);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'd0);
        end else if (out_ready) begin
          chk("out_data", out_data, expq.pop_front());
          chk("out_last", 64'(out_last),
              64'(retired == len - 1));
          if (lat) begin
            chk("latency", 64'(cyc - icyc[0]),
                64'(PIPE_LAT));
          end
          void'(icyc.pop_front());
          retired++;
          t_last = cyc;
        end
      end
      if (done) begin
        fin = 1'b1;
        chk("done_count", 64'(retired), 64'(len));
        if (len == 0) chk("done_lat0", 64'(k), 64'd1);
        else chk("done_lat", 64'(cyc - t_last), 64'd1);
      end else if (k > CLR_CYC) begin
        chk("ce_stall", 64'(mul_ce),
            64'(!(out_valid && !out_ready)));
      end
      tick();
      n++;
    end
    if (!fin) chk("done_seen", 64'(fin), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_done", 64'(done), 64'd0);
    chk("post_cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
  endtask

  initial begin
    sresetn       = 1'b0;
    cfg_valid     = 1'b0;
    cfg_precision = '0;
    cfg_fp        = '0;
    cfg_chain     = 1'b0;
    cfg_len       = '0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_weight     = '0;
    out_ready     = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("rst_sclr", 64'(mul_sclr), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    end
    chk("rst_ce", 64'(mul_ce), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    sresetn = 1'b1;
    @(negedge clk);
    chk("sclr_hold", 64'(mul_sclr), 64'd1);
    tick();
    @(negedge clk);
    chk("sclr_drop", 64'(mul_sclr), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_err", 64'(cfg_err), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    tick();

    run_job(PREC_INT64, 2'd0, 1'b0, 4, 0, 0, 1'b1, 1'b1);
    run_job(PREC_INT8,  2'd1, 1'b0, 8, 0, 1, 1'b0, 1'b0);
    run_job(PREC_INT16, 2'd0, 1'b1, 3, 1, 0, 1'b1, 1'b0);

    cfg_valid     = 1'b1;
    cfg_precision = 4'hF;
    cfg_len       = 8'd5;
    @(negedge clk);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("bad_err", 64'(cfg_err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_ready", 64'(cfg_ready), 64'd1);
    chk("bad_prec_kept",
        64'(mul_select_precision), 64'(last_prec));
    tick();
    @(negedge clk);
    chk("bad_err_pulse", 64'(cfg_err), 64'd0);
    chk("bad_busy2", 64'(busy), 64'd0);
    tick();

    run_job(PREC_INT32, 2'd2, 1'b1, 0, 0, 0, 1'b0, 1'b0);

    cfg_valid     = 1'b1;
    cfg_precision = PREC_INT32;
    cfg_len       = 8'd8;
    in_valid      = 1'b1;
    out_ready     = 1'b1;
    in_data       = {$urandom, $urandom};
    in_weight     = {$urandom, $urandom};
    tick();
    cfg_valid = 1'b0;
    repeat (5) tick();
    sresetn = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_sclr", 64'(mul_sclr), 64'd1);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_ce", 64'(mul_ce), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd0);
    chk("mid_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("mid_prec", 64'(mul_select_precision), 64'd0);
    tick();
    sresetn  = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();

    run_job(PREC_INT32, 2'd3, 1'b1, 6, 0, 0, 1'b1, 1'b0);
    for (int j = 0; j < 12; j++) begin
      run_job(4'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              int'($urandom_range(1, 20)),
              2, 2, 1'b0, 1'b0);
    end
    run_job(PREC_INT8, 2'd0, 1'b0, 255, 0, 2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
